rtype_exec_unit: RTL
====================

// Module: rtype_exec_unit
// PURPOSE
//  - Consumes 32-bit MIPS R-type instruction words from the fetch stage (inst_code).
//  - Decodes rs/rt/rd/shamt/funct, reads a 32x32 register file, executes on an ALU and writes back rd.
//  - Multi-cycle: one instruction per 4 clocks, with a valid/ready handshake toward fetch.
//  - Sits directly downstream of instruction fetch; it is the decode/execute/writeback half of the R-CPU.
// PARAMETERS
//  - DATA_W     32   datapath and register width
//  - REG_AW     5    register address width (2**REG_AW registers)
//  - CLEAR_RF   1    1: async reset clears all registers; 0: registers keep contents over reset
// PORTS
//  - clk        in   1       clock; all state updates on posedge
//  - rst        in   1       asynchronous, active-high reset
//  - inst_code  in   32      instruction word from fetch
//  - inst_valid in   1       inst_code is valid this cycle
//  - inst_ready out  1       unit accepts an instruction this cycle
//  - alu_result out  DATA_W  result of last executed instruction (held)
//  - zf         out  1       alu_result == 0 (registered with alu_result)
//  - of         out  1       signed overflow on add/sub (registered with alu_result)
//  - wb_done    out  1       1-cycle pulse: instruction retired (written or suppressed)
//  - illegal    out  1       1-cycle pulse with wb_done: opcode!=0 or funct unsupported
//  - dbg_addr   in   REG_AW  debug read address
//  - dbg_data   out  DATA_W  combinational read of register dbg_addr (r0 reads 0)
// BEHAVIOUR
//  - Reset (async): state=IDLE; inst_ready=1; alu_result=0; zf=1; of=0; wb_done=0; illegal=0;
//    instruction latch=0; registers cleared if CLEAR_RF=1.
//  - FSM: IDLE -> DEC -> EXE -> WB -> IDLE.
//    IDLE: inst_ready=1; on inst_valid&inst_ready, latch inst_code, go DEC; otherwise stay.
//    DEC:  read rs, rt into operand regs A, B; decode funct; go EXE.
//    EXE:  compute ALU on A, B, shamt; register alu_result, zf, of, illegal; go WB.
//    WB:   write rd = alu_result if !illegal && !of && rd!=0; pulse wb_done; go IDLE.
//  - inst_ready is 0 in DEC/EXE/WB. Latency: accept edge to wb_done = 3 clocks; throughput 1 per 4.
//  - Regfile write occurs on the clock edge leaving WB; an instruction accepted in the following
//    IDLE reads the new value (no forwarding required).
//  - funct: 20 add, 21 addu, 22 sub, 23 subu, 24 and, 25 or, 26 xor, 27 nor,
//    2A slt (signed), 2B sltu, 00 sll, 02 srl, 03 sra (shift rt by shamt).
//  - Arithmetic is modulo 2**DATA_W. of is set only for add/sub signed overflow; the write is then
//    suppressed but alu_result still shows the wrapped sum. addu/subu never set of.
//  - illegal: opcode[31:26]!=0 or funct not listed -> no write, alu_result=0, zf=1, of=0.
//  - rd=0: result is computed and flagged normally; r0 stays 0.
//  - rst asserted mid-instruction: aborts immediately, no write, back to IDLE.
//  - inst_valid while busy is ignored (fetch must hold the word until inst_ready).
// STRUCTURE
//  - Shared package/header: funct codes, opcode R-type=6'h00, state encodings (2-bit), field slices.
//  - Sub-module rtype_alu: combinational, inputs A, B, shamt, funct; outputs result, of, illegal.
//  - Register file is inline in this module (array + write in the WB state).
// TESTING
//  - Reset, then dbg_addr=0..31 -> dbg_data=0; inst_ready=1; zf=1.
//  - Preload r1=5, r2=7 via CLEAR_RF=0 force; add r3,r1,r2 (0x00221820) -> wb_done 3 clocks after accept,
//    r3=12, zf=0, of=0.
//  - r1=0x7FFFFFFF, r2=1; add r3 -> of=1, alu_result=0x80000000, r3 unchanged;
//    addu r3 -> r3=0x80000000, of=0.
//  - sub r4,r1,r1 -> r4=0, zf=1; slt with r1=-1, r2=1 -> 1; sltu -> 0;
//    sra r5,r1,4 with r1=0x80000000 -> 0xF8000000.
//  - opcode 0x08 or funct 0x3F -> illegal pulses with wb_done, no register changes;
//    write to rd=0 -> r0 stays 0.
//  - Hold inst_valid high continuously: exactly one accept per 4 clocks;
//    rst asserted in EXE -> no write, inst_ready=1 next cycle.

Source files
------------

// File: rtl/rtype_exec_unit_pkg.sv
// Shared definitions for the R-type execute unit: FSM states, opcode/funct
// codes and instruction field slices.
package rtype_exec_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DEC  = 2'd1,
    S_EXE  = 2'd2,
    S_WB   = 2'd3
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  function automatic logic [5:0] f_opcode(input logic [31:0] i);
    return i[31:26];
  endfunction

  function automatic logic [4:0] f_rs(input logic [31:0] i);
    return i[25:21];
  endfunction

  function automatic logic [4:0] f_rt(input logic [31:0] i);
    return i[20:16];
  endfunction

  function automatic logic [4:0] f_rd(input logic [31:0] i);
    return i[15:11];
  endfunction

  function automatic logic [4:0] f_shamt(input logic [31:0] i);
    return i[10:6];
  endfunction

  function automatic logic [5:0] f_funct(input logic [31:0] i);
    return i[5:0];
  endfunction

endpackage

// File: rtl/rtype_exec_unit_alu.sv
// Combinational R-type ALU: arithmetic, logic, compares and shifts (shifts act on b/rt).
module rtype_alu
  import rtype_exec_unit_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  output logic [DATA_W-1:0] result,
  output logic              of,
  output logic              illegal
);

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  // Select the operation; unsupported funct yields zero result and no overflow.
  always_comb begin
    result  = '0;
    of      = 1'b0;
    illegal = 1'b0;
    case (funct)
      F_ADD: begin
        result = sum;
        of     = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
      end
      F_ADDU: result = sum;
      F_SUB: begin
        result = diff;
        of     = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
      end
      F_SUBU: result = diff;
      F_AND:  result = a & b;
      F_OR:   result = a | b;
      F_XOR:  result = a ^ b;
      F_NOR:  result = ~(a | b);
      F_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      F_SLTU: result = {{(DATA_W-1){1'b0}}, (a < b)};
      F_SLL:  result = b << shamt;
      F_SRL:  result = b >> shamt;
      F_SRA:  result = $signed(b) >>> shamt;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rtype_exec_unit.sv
// Decode/execute/writeback half of a multi-cycle R-type CPU: one instruction
// per 4 clocks (IDLE -> DEC -> EXE -> WB), with an inline 32x32 register file.
module rtype_exec_unit
  import rtype_exec_unit_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned REG_AW   = 5,
  parameter bit          CLEAR_RF = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       inst_code,
  input  logic              inst_valid,
  output logic              inst_ready,
  output logic [DATA_W-1:0] alu_result,
  output logic              zf,
  output logic              of,
  output logic              wb_done,
  output logic              illegal,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int unsigned NREG = 2 ** REG_AW;

  state_t            state;
  logic [31:0]       inst_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              ill_q;
  logic [DATA_W-1:0] rf [NREG];

  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] alu_res;
  logic              alu_of;
  logic              alu_ill;
  logic              ex_ill;
  logic              wr_en;

  // r0 is hardwired to zero on every read port, so its storage is never trusted.
  assign rs_data  = (f_rs(inst_q) == '0) ? '0 : rf[f_rs(inst_q)];
  assign rt_data  = (f_rt(inst_q) == '0) ? '0 : rf[f_rt(inst_q)];
  assign dbg_data = (dbg_addr == '0) ? '0 : rf[dbg_addr];

  rtype_alu #(.DATA_W(DATA_W)) u_alu (
    .a       (a_q),
    .b       (b_q),
    .shamt   (f_shamt(inst_q)),
    .funct   (f_funct(inst_q)),
    .result  (alu_res),
    .of      (alu_of),
    .illegal (alu_ill)
  );

  assign ex_ill = (f_opcode(inst_q) != OP_RTYPE) || alu_ill;

  // Overflowing add/sub and illegal instructions retire without a write.
  assign wr_en = (state == S_WB) && !ill_q && !of && (f_rd(inst_q) != '0);

  // Sequencer: latch, read operands, execute/flag, retire; all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      inst_ready <= 1'b1;
      alu_result <= '0;
      zf         <= 1'b1;
      of         <= 1'b0;
      wb_done    <= 1'b0;
      illegal    <= 1'b0;
      inst_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      ill_q      <= 1'b0;
    end else begin
      wb_done <= 1'b0;
      illegal <= 1'b0;
      case (state)
        S_IDLE: begin
          if (inst_valid && inst_ready) begin
            inst_q     <= inst_code;
            inst_ready <= 1'b0;
            state      <= S_DEC;
          end
        end
        S_DEC: begin
          a_q   <= rs_data;
          b_q   <= rt_data;
          state <= S_EXE;
        end
        S_EXE: begin
          if (ex_ill) begin
            alu_result <= '0;
            zf         <= 1'b1;
            of         <= 1'b0;
          end else begin
            alu_result <= alu_res;
            zf         <= (alu_res == '0);
            of         <= alu_of;
          end
          ill_q <= ex_ill;
          state <= S_WB;
        end
        S_WB: begin
          wb_done    <= 1'b1;
          illegal    <= ill_q;
          inst_ready <= 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Register file write on the edge leaving WB; reset clearing is optional.
  // An async reset forces state to IDLE immediately, so wr_en drops and an
  // aborted instruction can never write in either variant.
  generate
    if (CLEAR_RF) begin : g_rf_clear
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rf <= '{default: '0};
        end else if (wr_en) begin
          rf[f_rd(inst_q)] <= alu_result;
        end
      end
    end else begin : g_rf_keep
      always_ff @(posedge clk) begin
        if (wr_en) begin
          rf[f_rd(inst_q)] <= alu_result;
        end
      end
    end
  endgenerate

endmodule
